// File: rtl/truth_table_monitor.sv
// Captures a 4-input truth table from sample strobes and grades it against EXPECTED; results register one edge after each sample.
// Never stalls: there is no ready, samples outside COLLECT or in a start cycle are dropped.
`timescale 1ns/1ps
module truth_table_monitor #(
    parameter logic [15:0] EXPECTED = 16'h6996,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        smp_valid,
    input  logic [3:0]  smp_vec,
    input  logic        smp_f,
    output logic [15:0] table_out,
    output logic [15:0] covered,
    output logic [4:0]  mismatch_cnt,
    output logic [3:0]  first_err_vec,
    output logic        first_err_valid,
    output logic        conflict,
    output logic        timeout,
    output logic        busy,
    output logic        done,
    output logic        pass
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [15:0] TO = TIMEOUT[15:0];

    state_t      state;
    state_t      state_nxt;
    logic [15:0] idle_cnt;

    logic        accept;
    logic        is_new;
    logic        is_rep;
    logic        bad_new;
    logic [15:0] vec_onehot;
    logic [15:0] cov_nxt;
    logic        idle_hit;
    logic [15:0] idle_inc;

    assign accept     = (state == COLLECT) && smp_valid && !start;
    assign is_new     = accept && !covered[smp_vec];
    assign is_rep     = accept && covered[smp_vec];
    assign bad_new    = is_new && (smp_f != EXPECTED[smp_vec]);
    assign vec_onehot = 16'(1) << smp_vec;
    assign cov_nxt    = is_new ? (covered | vec_onehot) : covered;

    // Timeout fires on the idle cycle that brings the counter up to TO.
    assign idle_hit = (TO != 16'd0) && (state == COLLECT) && !is_new
                      && (idle_cnt >= TO - 16'd1);

    always_comb begin
        idle_inc = idle_cnt;
        if (TO == 16'd0) begin
            if (idle_cnt != 16'hFFFF) idle_inc = idle_cnt + 16'd1;
        end else if (idle_cnt < TO) begin
            idle_inc = idle_cnt + 16'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: begin
                if (cov_nxt == 16'hFFFF) state_nxt = DONE;
                else if (idle_hit)       state_nxt = DONE;
            end
            default: state_nxt = state;
        endcase
        if (start) state_nxt = COLLECT;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst || start) begin
            table_out       <= 16'd0;
            covered         <= 16'd0;
            mismatch_cnt    <= 5'd0;
            first_err_vec   <= 4'd0;
            first_err_valid <= 1'b0;
            conflict        <= 1'b0;
            timeout         <= 1'b0;
            idle_cnt        <= 16'd0;
        end else if (state == COLLECT) begin
            if (is_new) begin
                table_out[smp_vec] <= smp_f;
                covered[smp_vec]   <= 1'b1;
                idle_cnt           <= 16'd0;
                if (bad_new) begin
                    mismatch_cnt <= mismatch_cnt + 5'd1;
                    if (!first_err_valid) begin
                        first_err_vec   <= smp_vec;
                        first_err_valid <= 1'b1;
                    end
                end
            end else begin
                idle_cnt <= idle_inc;
                if (idle_hit) timeout <= 1'b1;
            end
            // A repeat never rewrites the table; disagreement is only flagged.
            if (is_rep && (smp_f != table_out[smp_vec])) conflict <= 1'b1;
        end
    end

    assign busy = (state == COLLECT);
    assign done = (state == DONE);
    assign pass = done && (covered == 16'hFFFF) && (mismatch_cnt == 5'd0)
                  && !conflict && !timeout;

endmodule

// File: tb/tb_truth_table_monitor.sv
// Directed bench for truth_table_monitor: full sweeps, mismatches, conflicts, timeout, reset/start priority, DONE hold.
`timescale 1ns/1ps
module tb_truth_table_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        smp_valid;
    logic [3:0]  smp_vec;
    logic        smp_f;
    logic [15:0] table_out;
    logic [15:0] covered;
    logic [4:0]  mismatch_cnt;
    logic [3:0]  first_err_vec;
    logic        first_err_valid;
    logic        conflict;
    logic        timeout;
    logic        busy;
    logic        done;
    logic        pass;

    int errors = 0;
    int checks = 0;

    truth_table_monitor #(.EXPECTED(16'h6996), .TIMEOUT(64)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .smp_valid(smp_valid),
        .smp_vec(smp_vec),
        .smp_f(smp_f),
        .table_out(table_out),
        .covered(covered),
        .mismatch_cnt(mismatch_cnt),
        .first_err_vec(first_err_vec),
        .first_err_valid(first_err_valid),
        .conflict(conflict),
        .timeout(timeout),
        .busy(busy),
        .done(done),
        .pass(pass)
    );

    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are observed 1ns after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [3:0] v, input logic f);
        smp_valid = 1'b1;
        smp_vec   = v;
        smp_f     = f;
        cyc();
        smp_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    // Sends vectors 0..15 in order; inv flips F (relative to parity) per vector.
    task automatic sweep(input logic [15:0] inv);
        logic [3:0] vv;
        for (int i = 0; i < 16; i++) begin
            vv = i[3:0];
            send(vv, (^vv) ^ inv[i]);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tbl"},  32'(table_out), 32'h0);
        check({tag, "_cov"},  32'(covered), 32'h0);
        check({tag, "_flags"},
              32'({mismatch_cnt, first_err_vec, first_err_valid, conflict, timeout, busy, done, pass}),
              32'h0);
    endtask

    initial begin
        logic [3:0] vv;
        rst = 1'b1; start = 1'b0; smp_valid = 1'b0; smp_vec = 4'd0; smp_f = 1'b0;
        idle(2);
        check_all_zero("reset");
        rst = 1'b0;
        cyc();

        // 1: clean in-order sweep
        do_start();
        check("t1_busy", 32'(busy), 32'h1);
        for (int i = 0; i < 15; i++) begin
            vv = i[3:0];
            send(vv, ^vv);
        end
        check("t1_done_early", 32'(done), 32'h0);
        send(4'd15, 1'b0);
        check("t1_done", 32'(done), 32'h1);
        check("t1_tbl", 32'(table_out), 32'h6996);
        check("t1_cov", 32'(covered), 32'hFFFF);
        check("t1_mm", 32'(mismatch_cnt), 32'h0);
        check("t1_pass", 32'(pass), 32'h1);

        // 2: inverted F at vectors 5 and 10
        do_start();
        sweep(16'h0420);
        check("t2_tbl", 32'(table_out), 32'h6DB6);
        check("t2_mm", 32'(mismatch_cnt), 32'd2);
        check("t2_fev", 32'(first_err_vec), 32'd5);
        check("t2_fevv", 32'(first_err_valid), 32'h1);
        check("t2_done", 32'(done), 32'h1);
        check("t2_pass", 32'(pass), 32'h0);

        // 3: descending with gaps, then repeats of vector 3 before the last vector
        do_start();
        for (int i = 15; i >= 1; i--) begin
            vv = i[3:0];
            send(vv, ^vv);
            idle(3);
        end
        send(4'd3, 1'b0);
        check("t3_rep_same", 32'(conflict), 32'h0);
        send(4'd3, 1'b1);
        check("t3_rep_diff", 32'(conflict), 32'h1);
        check("t3_mm", 32'(mismatch_cnt), 32'h0);
        check("t3_tbl3", 32'(table_out[3]), 32'h0);
        check("t3_busy", 32'(busy), 32'h1);
        send(4'd0, 1'b0);
        check("t3_done", 32'(done), 32'h1);
        check("t3_cov", 32'(covered), 32'hFFFF);
        check("t3_pass", 32'(pass), 32'h0);

        // 4: samples in IDLE ignored, partial sweep then timeout
        rst = 1'b1; cyc(); rst = 1'b0;
        send(4'd2, 1'b1);
        send(4'd9, 1'b0);
        check("t4_idle_cov", 32'(covered), 32'h0);
        check("t4_idle_busy", 32'(busy), 32'h0);
        do_start();
        for (int i = 0; i < 8; i++) begin
            vv = i[3:0];
            send(vv, ^vv);
        end
        idle(63);
        check("t4_done_63", 32'(done), 32'h0);
        check("t4_to_63", 32'(timeout), 32'h0);
        idle(1);
        check("t4_done_64", 32'(done), 32'h1);
        check("t4_to_64", 32'(timeout), 32'h1);
        check("t4_cov", 32'(covered), 32'h00FF);
        check("t4_pass", 32'(pass), 32'h0);

        // 5a: reset mid-collection
        do_start();
        for (int i = 0; i < 6; i++) begin
            vv = i[3:0];
            send(vv, ~(^vv));
        end
        check("t5_mm_pre", 32'(mismatch_cnt), 32'd6);
        rst = 1'b1; start = 1'b1;
        cyc();
        rst = 1'b0; start = 1'b0;
        check_all_zero("t5_rst");
        // 5b: start mid-collection; the start-cycle sample is dropped
        do_start();
        for (int i = 0; i < 6; i++) begin
            vv = i[3:0];
            send(vv, ~(^vv));
        end
        start = 1'b1; smp_valid = 1'b1; smp_vec = 4'd6; smp_f = 1'b1;
        cyc();
        start = 1'b0; smp_valid = 1'b0;
        check("t5_cov", 32'(covered), 32'h0);
        check("t5_mm", 32'(mismatch_cnt), 32'h0);
        check("t5_fevv", 32'(first_err_valid), 32'h0);
        check("t5_busy", 32'(busy), 32'h1);
        sweep(16'h0000);
        check("t5_pass", 32'(pass), 32'h1);

        // 6: DONE holds against wrong samples, then restart
        send(4'd0, 1'b1);
        send(4'd7, 1'b0);
        check("t6_tbl", 32'(table_out), 32'h6996);
        check("t6_conf", 32'(conflict), 32'h0);
        check("t6_mm", 32'(mismatch_cnt), 32'h0);
        check("t6_pass", 32'(pass), 32'h1);
        do_start();
        check("t6_restart_cov", 32'(covered), 32'h0);
        check("t6_restart_pass", 32'(pass), 32'h0);
        sweep(16'h0000);
        check("t6_pass2", 32'(pass), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/truth_table_monitor.md
Name: truth_table_monitor

Overview:
- Response-side companion to the exhaustive 4-input truth-table stimulus sequencer.
- Accepts {vector, F} sample strobes from the device-under-observation and builds the captured 16-entry truth table.
- Tracks which vectors have been seen and compares each first capture against a golden table.
- Reports done, pass, mismatch count, first failing vector, conflicts and timeout, for self-checking benches and on-board BIST.

Parameters:
- EXPECTED, 16'h6996, golden truth table; bit i = required F for input i, where i = {A,B,C,D} and A is the MSB.
- TIMEOUT, 64, max cycles in COLLECT without a new vector before forced DONE; 0 disables the timeout.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  clears all results and enters COLLECT (accepted in any state).
- smp_valid  input  1  sample strobe, one sample per cycle.
- smp_vec  input  4  input vector {A,B,C,D} applied to the DUT.
- smp_f  input  1  DUT output F for smp_vec.
- table_out  output  16  captured F per vector.
- covered  output  16  bit i set once vector i has been captured.
- mismatch_cnt  output  5  count of first captures differing from EXPECTED (0..16).
- first_err_vec  output  4  vector of the earliest mismatch.
- first_err_valid  output  1  first_err_vec holds a valid value.
- conflict  output  1  sticky; a repeat sample of a vector disagreed with its stored value.
- timeout  output  1  sticky; DONE was reached by timeout.
- busy  output  1  state is COLLECT.
- done  output  1  state is DONE.
- pass  output  1  done & all covered & mismatch_cnt==0 & !conflict & !timeout.

Behaviour:
- All outputs are registered and update on the clock edge after the accepting sample.
- Reset (rst=1 on a clock edge, including mid-collection): state=IDLE. table_out, covered, mismatch_cnt, first_err_vec, first_err_valid, conflict, timeout, busy, done, pass are all 0. The idle counter is 0.
- rst has priority over start.
- States:
  - IDLE: smp_valid is ignored. start -> COLLECT.
  - COLLECT: processes samples as below.
    - Goes to DONE when covered becomes 16'hFFFF, including via the sample in the current cycle. done=1 in the next cycle.
    - Goes to DONE when the idle counter reaches TIMEOUT; timeout is set to 1.
  - DONE: holds all results; smp_valid is ignored. start -> COLLECT.
- start (any state): on the same edge, clears every result register and the idle counter, and sets state=COLLECT. A sample presented in the start cycle is ignored.
- Sample processing in COLLECT when smp_valid=1, with v = smp_vec:
  - If covered[v]=0 (new vector):
    - table_out[v] <= smp_f; covered[v] <= 1.
    - If smp_f != EXPECTED[v]: mismatch_cnt increments by 1.
    - If smp_f != EXPECTED[v] and first_err_valid=0: first_err_vec <= v and first_err_valid <= 1.
    - The idle counter resets to 0.
  - If covered[v]=1 (repeat vector):
    - The table keeps its first value and mismatch_cnt is unchanged.
    - If smp_f != table_out[v]: conflict <= 1.
    - The idle counter is not reset.
- Idle counter: increments every COLLECT cycle without a new vector and saturates at TIMEOUT. It is 16 bits wide; TIMEOUT must be < 65536.
- mismatch_cnt cannot exceed 16 (each vector is counted at most once), so it never wraps.
- Sample order is arbitrary; vectors may arrive out of order or with gaps.
- pass is combinational from the registered flags, qualified by done.

Test Plan:
1. rst, start, then vectors 0..15 one per cycle with F = parity (EXPECTED) -> done=1 one cycle after vector 15. table_out=16'h6996, covered=16'hFFFF, mismatch_cnt=0, pass=1.
2. Same sequence but F inverted at vectors 5 and 10 -> table_out=16'h6DB6, mismatch_cnt=2, first_err_vec=5, first_err_valid=1, pass=0.
3. Vectors 15 down to 0 with 3 idle cycles between samples, repeat vector 3 with the same F, then repeat vector 3 with inverted F -> the first repeat leaves conflict=0. The second repeat sets conflict=1 with mismatch_cnt unchanged. Final result is done=1 and pass=0.
4. smp_valid pulses in IDLE then start, vectors 0..7 only, idle -> IDLE samples leave covered=0. After TIMEOUT (64) idle cycles: done=1, timeout=1, covered=16'h00FF, pass=0.
5. Assert rst after 6 vectors -> all outputs 0 and state IDLE next cycle. Separately, start asserted after 6 vectors -> results cleared and a full clean sweep then gives pass=1.
6. In DONE, apply samples with wrong F -> no output changes. start followed by a clean sweep -> pass=1.
